block_accumulator: RTL and testbench
====================================

Name: block_accumulator

Overview:
- Stage directly downstream of the registered signed adder.
- Consumes the adder's DOW-wide sum stream and accumulates a programmable number of consecutive valid samples into one block sum.
- Presents each block result on a valid/ready output toward the next pipeline stage.
- The input side has no backpressure, because the adder stage has none; an unaccepted result is flagged as an overrun.

Parameters:
- DIW, 33, input sample width; matches the adder output width DOW for a 32-bit adder.
- LEN_W, 8, width of the block-length field; supports up to 2^LEN_W samples per block.
- ACCW, DIW + LEN_W, accumulator and output width; guarantees no overflow for any legal block.

Ports:
- clk  input  1  single clock for the block; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; aborts the current block, drops the pending result, clears err_overrun.
- blk_len  input  LEN_W  samples per block minus 1; sampled only when a block starts.
- in_valid  input  1  in_data is valid this cycle; always accepted.
- in_data  input  DIW  signed sample (adder sum).
- out_valid  output  1  result pending.
- out_ready  input  1  downstream accepts the result when out_valid is also high.
- out_data  output  ACCW  signed block sum.
- busy  output  1  a block is in progress (state ACC).
- err_overrun  output  1  sticky flag: a completed result overwrote an unaccepted one.

Behaviour:
- Reset (rst_n low, asynchronous) clears the following:
  - state = IDLE; acc, cnt, len_q = 0
  - out_valid = 0, out_data = 0
  - busy = 0, err_overrun = 0
- Priority, highest first: rst_n, then clr, then the normal operation below.
- Arithmetic: in_data is sign-extended to ACCW before every add. Sums are exact two's complement; no saturation or wrap is possible.
- IDLE state, on in_valid:
  - If blk_len == 0, the block completes immediately with result = in_data, and the state stays IDLE.
  - Otherwise: acc <= in_data, cnt <= 1, len_q <= blk_len, go to ACC.
- ACC state, on in_valid:
  - If cnt == len_q, the block completes with result = acc + in_data, and the state goes to IDLE.
  - Otherwise: acc <= acc + in_data, cnt <= cnt + 1.
- ACC state, in_valid low: hold all state. Gaps inside a block are legal and do not change the result.
- blk_len changes while in ACC are ignored until the next block start.
- Completion:
  - out_data <= result and out_valid <= 1 on the same edge.
  - Latency is one cycle: out_valid is high in the cycle after the last sample's in_valid.
- Handshake:
  - Transfer occurs when out_valid and out_ready are both high; out_valid then drops next cycle unless a completion coincides.
  - While out_valid is high and out_ready is low, out_data stays stable.
- Completion in the same cycle as a transfer: the new result loads and out_valid stays 1, with no overrun.
- Completion while out_valid is high and out_ready is low: the new result overwrites out_data and err_overrun is set to 1, sticky until clr or reset.
- Back-to-back blocks: the first sample of the next block may arrive in the cycle immediately after the completing sample. With blk_len == 0, every valid sample is one block.
- clr:
  - Next state is IDLE; acc and cnt = 0; out_valid = 0; err_overrun = 0.
  - A sample presented in the clr cycle is discarded.
- Reset mid-block: the partial sum is lost and no output is produced; the first sample after reset starts a new block.
- busy = (state == ACC).

Decomposition:
- Package block_accum_pkg holds:
  - the state enum type (IDLE, ACC);
  - a function for the accumulator width (DIW + LEN_W);
  - a sign-extension helper.
- One sub-module is natural: accum_out_reg, the result register with valid/ready hold and overrun detection. The accumulate FSM remains in the top module.

Test Plan:
- blk_len=3, in_data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data=10 with out_valid high for exactly one cycle, one cycle after sample 4.
- DIW=33, blk_len=3, four samples of -2^32 -> out_data = -2^34 exactly; then four samples of 2^32-1 -> 2^34-4; no wrap.
- blk_len=0, samples 5, -7, 9 with idle gaps between them, out_ready=1 -> three results 5, -7, 9, each one cycle after its sample; busy never asserts.
- blk_len=1, out_ready=0, samples 1,1 then 2,2 -> out_data=4, err_overrun=1, out_valid held. Then out_ready=1 -> a single transfer of 4. Then clr -> err_overrun=0.
- blk_len=2, block A's result is accepted with out_ready=1 in the same cycle that block B's last sample arrives -> out_valid stays high, out_data switches to B's sum, err_overrun stays 0.
- rst_n pulsed low asynchronously after 2 of 4 samples -> all outputs 0 immediately; a fresh 4-sample block 1,1,1,1 afterwards -> out_data=4.

Source files
------------

// File: rtl/block_accum_pkg.sv
// Shared types and helpers for the block accumulator.
package block_accum_pkg;

  localparam int unsigned DIW_DEF   = 33;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned SEXT_MAXW = 64;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Accumulator width wide enough for 2^len_w samples of diw bits.
  function automatic int unsigned acc_width(input int unsigned diw, input int unsigned len_w);
    return diw + len_w;
  endfunction

  // Sign-extend the low w bits of x to SEXT_MAXW bits.
  function automatic logic [SEXT_MAXW-1:0] sext(input logic [SEXT_MAXW-1:0] x, input int unsigned w);
    logic [SEXT_MAXW-1:0] r;
    r = x << (SEXT_MAXW - w);
    r = $unsigned($signed(r) >>> (SEXT_MAXW - w));
    return r;
  endfunction

endpackage

// File: rtl/block_accumulator_if.sv
// Sample input stream and valid/ready result output of the accumulator.
interface block_accumulator_if #(
  parameter int unsigned DIW  = 33,
  parameter int unsigned ACCW = 41
);
  logic            in_valid;
  logic [DIW-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/block_accumulator_out_reg.sv
// Result register: holds a block sum until accepted, flags overwrites.
module accum_out_reg #(
  parameter int unsigned W = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_overrun
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_overrun;

  // Load on completion, drop valid on transfer, sticky overrun on overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else if (i_clr) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      if (r_valid && !i_ready) r_overrun <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/block_accumulator.sv
// Accumulates a programmable number of signed samples into one block sum.
module block_accumulator
  import block_accum_pkg::*;
#(
  parameter int unsigned DIW   = DIW_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [LEN_W-1:0]     blk_len,
  block_accumulator_if.slave   bus,
  output logic                 busy,
  output logic                 err_overrun
);

  localparam int unsigned ACCW = acc_width(DIW, LEN_W);

  state_t            r_state;
  logic [ACCW-1:0]   r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len_q;

  logic [ACCW-1:0]   w_samp;
  logic [ACCW-1:0]   w_sum;
  logic [ACCW-1:0]   w_result;
  logic              w_done;

  assign w_samp = ACCW'(sext(SEXT_MAXW'(bus.in_data), DIW));
  assign w_sum  = r_acc + w_samp;

  // Detect the last sample of a block and select its result.
  always_comb begin
    w_done   = 1'b0;
    w_result = w_samp;
    if (bus.in_valid && !clr) begin
      if (r_state == IDLE) begin
        w_done = (blk_len == '0);
      end else begin
        w_done   = (r_cnt == r_len_q);
        w_result = w_sum;
      end
    end
  end

  // Accumulate FSM: a block starts on the first valid sample in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len_q <= '0;
    end else if (clr) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (bus.in_valid) begin
      case (r_state)
        IDLE: begin
          if (blk_len != '0) begin
            r_acc   <= w_samp;
            r_cnt   <= LEN_W'(1);
            r_len_q <= blk_len;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (r_cnt == r_len_q) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == ACC);

  accum_out_reg #(
    .W (ACCW)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (clr),
    .i_load    (w_done),
    .i_data    (w_result),
    .i_ready   (bus.out_ready),
    .o_valid   (bus.out_valid),
    .o_data    (bus.out_data),
    .o_overrun (err_overrun)
  );

endmodule

// File: tb/tb_block_accumulator.sv
// Directed bench for block_accumulator with a behavioural block-sum model.
module tb_block_accumulator;

  localparam int unsigned DIW   = 33;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned ACCW  = 41;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic [LEN_W-1:0] blk_len = '0;
  logic             busy;
  logic             err_overrun;
  bit               chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  block_accumulator_if #(.DIW(DIW), .ACCW(ACCW)) bus ();

  block_accumulator #(.DIW(DIW), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .blk_len     (blk_len),
    .bus         (bus),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  // Model state: block in progress, samples still owed, running sum, result slot.
  typedef struct {
    bit     in_blk;
    int     left;
    longint sum;
    bit     valid;
    longint data;
    bit     ovr;
  } m_t;

  m_t m;

  function automatic m_t step(input m_t s, input bit v, input longint d, input int bl,
                              input bit rdy, input bit c);
    m_t n;
    bit fin;
    n   = s;
    fin = 1'b0;
    if (c) begin
      n.in_blk = 1'b0;
      n.sum    = 0;
      n.valid  = 1'b0;
      n.ovr    = 1'b0;
      return n;
    end
    if (v) begin
      if (!s.in_blk) begin
        n.sum  = d;
        n.left = bl;
      end else begin
        n.sum  = s.sum + d;
        n.left = s.left - 1;
      end
      fin      = (n.left == 0);
      n.in_blk = !fin;
    end
    if (fin) begin
      if (s.valid && !rdy) n.ovr = 1'b1;
      n.valid = 1'b1;
      n.data  = n.sum;
    end else if (s.valid && rdy) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else m <= step(m, bus.in_valid, longint'($signed(bus.in_data)), int'(blk_len),
                   bus.out_ready, clr);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle once out of reset.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("out_valid", longint'(bus.out_valid), longint'(m.valid));
      chk("busy", longint'(busy), longint'(m.in_blk));
      chk("err_overrun", longint'(err_overrun), longint'(m.ovr));
      if (m.valid) chk("out_data", longint'($signed(bus.out_data)), m.data);
    end
  end

  // One clock of stimulus; returns at the following falling edge.
  task automatic cyc(input bit v, input longint d, input int bl, input bit rdy, input bit c);
    bus.in_valid  = v;
    bus.in_data   = DIW'(d);
    blk_len       = LEN_W'(bl);
    bus.out_ready = rdy;
    clr           = c;
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input bit v, input longint d);
    chk({name, "_valid"}, longint'(bus.out_valid), longint'(v));
    if (v) chk({name, "_data"}, longint'($signed(bus.out_data)), d);
  endtask

  longint neg32;
  longint pos32;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    neg32 = -(longint'(1) <<< 32);
    pos32 = (longint'(1) <<< 32) - 1;

    @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_overrun", longint'(err_overrun), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 4-sample block 1..4
    cyc(1, 1, 3, 1, 0);
    cyc(1, 2, 3, 1, 0);
    cyc(1, 3, 3, 1, 0);
    chk("t1_busy", longint'(busy), 1);
    chk_out("t1_pre", 0, 0);
    cyc(1, 4, 3, 1, 0);
    chk_out("t1", 1, 10);
    chk("t1_model", m.data, 10);
    cyc(0, 0, 3, 1, 0);
    chk_out("t1_post", 0, 0);

    // Extreme magnitudes, no wrap
    repeat (4) cyc(1, neg32, 3, 1, 0);
    chk_out("t2_neg", 1, -64'sd17179869184);
    repeat (4) cyc(1, pos32, 3, 1, 0);
    chk_out("t2_pos", 1, 64'sd17179869180);
    chk("t2_model", m.data, 64'sd17179869180);
    cyc(0, 0, 3, 1, 0);

    // Single-sample blocks with gaps
    cyc(1, 5, 0, 1, 0);
    chk_out("t3_a", 1, 5);
    chk("t3_busy", longint'(busy), 0);
    cyc(0, 0, 0, 1, 0);
    chk_out("t3_gap", 0, 0);
    cyc(1, -7, 0, 1, 0);
    chk_out("t3_b", 1, -7);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 9, 0, 1, 0);
    chk_out("t3_c", 1, 9);
    cyc(0, 0, 0, 1, 0);

    // Overrun with stalled downstream
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk_out("t4_first", 1, 2);
    cyc(1, 2, 1, 0, 0);
    chk_out("t4_hold", 1, 2);
    cyc(1, 2, 1, 0, 0);
    chk_out("t4_over", 1, 4);
    chk("t4_ovr", longint'(err_overrun), 1);
    cyc(0, 0, 1, 0, 0);
    chk_out("t4_held", 1, 4);
    cyc(0, 0, 1, 1, 0);
    chk_out("t4_xfer", 0, 0);
    chk("t4_ovr_sticky", longint'(err_overrun), 1);
    cyc(0, 0, 1, 1, 1);
    chk("t4_clr_ovr", longint'(err_overrun), 0);

    // Completion coinciding with transfer
    cyc(1, 1, 2, 0, 0);
    cyc(1, 2, 2, 0, 0);
    cyc(1, 3, 2, 0, 0);
    chk_out("t5_a", 1, 6);
    cyc(1, 10, 2, 0, 0);
    cyc(1, 20, 2, 0, 0);
    chk_out("t5_a_hold", 1, 6);
    cyc(1, 30, 2, 1, 0);
    chk_out("t5_b", 1, 60);
    chk("t5_ovr", longint'(err_overrun), 0);
    cyc(0, 0, 2, 1, 0);
    chk_out("t5_post", 0, 0);

    // Asynchronous reset mid-block
    cyc(1, 1, 3, 1, 0);
    cyc(1, 1, 3, 1, 0);
    chk("t6_busy", longint'(busy), 1);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", longint'(busy), 0);
    chk("t6_rst_valid", longint'(bus.out_valid), 0);
    chk("t6_rst_data", longint'(bus.out_data), 0);
    chk("t6_rst_ovr", longint'(err_overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc(1, 1, 3, 1, 0);
    chk_out("t6_fresh", 1, 4);
    cyc(0, 0, 3, 1, 0);
    cyc(0, 0, 3, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
